// File: rtl/ldpc_mem_pkg.sv
// ldpc_mem_pkg: shared geometry constants and FSM encoding for the LDPC message RAM loader.
package ldpc_mem_pkg;
   localparam int LLR_WIDTH  = 5;
   localparam int LANES      = 3;
   localparam int DATA_WIDTH = LLR_WIDTH * LANES;
   localparam int ADDR_WIDTH = 8;
   localparam int CNT_WIDTH  = 10;
   typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;
endpackage

// File: rtl/llr_lane_packer.sv
// llr_lane_packer: places each accepted LLR into its lane and flags the word-completing accept.
module llr_lane_packer
   import ldpc_mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  accept,
   input  logic [LLR_WIDTH-1:0]  llr,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_done
);
   logic [1:0]            lane_cnt;
   logic [DATA_WIDTH-1:0] pack;

   // Unfilled upper lanes stay zero, so a partial word is ready to flush as-is.
   always_comb begin
      word = pack;
      for (int i = 0; i < LANES; i++)
         if (lane_cnt == 2'(i)) word[i*LLR_WIDTH +: LLR_WIDTH] = llr;
   end

   assign word_done = accept && lane_cnt == 2'(LANES - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt <= '0;
         pack     <= '0;
      end else if (clr) begin
         lane_cnt <= '0;
         pack     <= '0;
      end else if (accept) begin
         lane_cnt <= word_done ? 2'd0 : lane_cnt + 2'd1;
         pack     <= word_done ? '0 : word;
      end
   end
endmodule

// File: rtl/llr_word_packer.sv
// llr_word_packer: streams LLRs into 3-lane RAM words with single-cycle write strobes.
// PARTIAL_FLUSH_EN: when defined, a trailing partial word is written with zeroed unused lanes.
module llr_word_packer
   import ldpc_mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_llr,
   input  logic [LLR_WIDTH-1:0]  llr_in,
   input  logic                  llr_valid,
   output logic                  llr_ready,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_we,
   output logic                  ram_cs,
   output logic                  busy,
   output logic                  done
);
   state_t                state, state_nx;
   logic [CNT_WIDTH-1:0]  num_q, cnt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] word;
   logic                  go, accept, last_llr, word_done, write;

   assign go        = state == IDLE && start;
   assign llr_ready = state == RUN;
   assign accept    = llr_valid && llr_ready;
   assign last_llr  = accept && cnt == num_q - 1'b1;
   assign busy      = state == RUN || state == LAST;
   assign done      = state == DONE;
   assign ram_we    = ram_cs;
`ifdef PARTIAL_FLUSH_EN
   assign write = word_done || last_llr;
`else
   assign write = word_done;
`endif

   llr_lane_packer u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (go),
      .accept    (accept),
      .llr       (llr_in),
      .word      (word),
      .word_done (word_done)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = num_llr == '0 ? DONE : RUN;
         RUN:     if (last_llr) state_nx = LAST;
         LAST:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         num_q       <= '0;
         cnt         <= '0;
         ptr         <= '0;
         ram_address <= '0;
         ram_data_in <= '0;
         ram_cs      <= 1'b0;
      end else begin
         state  <= state_nx;
         ram_cs <= write;
         if (go) begin
            num_q <= num_llr;
            cnt   <= '0;
            ptr   <= base_addr;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end
         if (write) begin
            ram_address <= ptr;
            ram_data_in <= word;
            ptr         <= ptr + 1'b1;
         end
      end
   end
endmodule
